chacha_block_client: RTL and testbench
======================================

# chacha_block_client

Initiator-side peer for the UART ChaCha20 block engine. It packs a local plaintext byte stream into 64-byte blocks, zero-pads the final partial block, and sends each block out through a `uart_tx` byte interface. It then collects the 64 returned bytes from a `uart_rx` byte interface and replays only the meaningful bytes on a local output stream. A block counter mirrors the engine's ChaCha counter, and a receive watchdog flags loss of lock-step with the engine.

## Interface
- `BLOCK_BYTES`, 64: bytes per block. Fixed by the engine; other values are unsupported.
- `TIMEOUT_CYCLES`, 27_000_000: idle cycles allowed in RECV before error (1 s at 27 MHz). Width 32.
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `in_data`  in  8  plaintext byte
- `in_valid`  in  1  `in_data` valid
- `in_last`  in  1  qualifies final byte of a message
- `in_ready`  out  1  block accepts input byte
- `utx_data`  out  8  byte to `uart_tx`
- `utx_valid`  out  1  `utx_data` valid
- `utx_ready`  in  1  `uart_tx` accepts byte
- `urx_data`  in  8  byte from `uart_rx`
- `urx_valid`  in  1  one-cycle strobe; no backpressure, always consumed
- `out_data`  out  8  returned (ciphertext) byte
- `out_valid`  out  1  `out_data` valid
- `out_last`  out  1  final byte of message
- `out_ready`  in  1  sink accepts byte
- `blk_count`  out  32  completed blocks since reset (equals engine `ctr` low bits)
- `busy`  out  1  state ≠ FILL, or a block is partially filled
- `err`  out  1  watchdog fired; sticky until `rst`

## Operation
- Storage: `tx_buf[64]`, `rx_buf[64]`, `idx` (7 b), `len` (7 b, 1..64), `last_flg`, `timer` (32 b).
- **FILL** (reset state)
  - `in_ready`=1; each handshake writes `tx_buf[idx]` and increments `idx`.
  - On a handshake with `in_last`=1 or `idx`==63: `len`←`idx`+1, `last_flg`←`in_last`, `idx`←0, go to SEND.
- **SEND**
  - `utx_valid`=1, `utx_data` = `tx_buf[idx]` if `idx`<`len`, else 0x00 (padding).
  - Each handshake increments `idx`. The handshake at `idx`==63 sets `idx`←0, `timer`←0 and goes to RECV.
- **RECV**
  - Each `urx_valid` writes `rx_buf[idx]`, increments `idx`, clears `timer`. Otherwise `timer` increments.
  - The byte at `idx`==63 sets `idx`←0 and goes to DRAIN.
  - If `timer`==`TIMEOUT_CYCLES`-1 with no `urx_valid` that cycle, go to ERR. A byte arriving on that cycle wins.
- **DRAIN**
  - `out_valid`=1, `out_data`=`rx_buf[idx]`, `out_last` = `last_flg` && `idx`==`len`-1.
  - Bytes at index ≥`len` are discarded and never presented.
  - The handshake at `idx`==`len`-1 sets `blk_count`++ (wraps 2^32-1→0), `idx`←0 and returns to FILL.
- **ERR**: `err`=1; `in_ready`, `utx_valid` and `out_valid` are all 0. Exits only on `rst`.
- `urx_valid` outside RECV is ignored; no buffer or state change.
- `blk_count` does not reset on `in_last`; it tracks the engine counter across messages.
- A message whose length is an exact multiple of 64 ends with a full block where `len`=64 and `last_flg`=1.

## Timing
- Reset values: `in_ready`=0 during `rst`, 1 on the first cycle after. `utx_valid`=0, `utx_data`=0x00, `out_valid`=0, `out_data`=0x00, `out_last`=0, `blk_count`=0, `busy`=0, `err`=0. State is FILL with `idx`=0. Buffer contents are not cleared.
- All outputs are decoded from registers only. There is no combinational path from `utx_ready`, `out_ready` or `in_valid` to any output.
- Final input handshake at cycle N: `utx_valid`=1 at N+1.
- 64th `utx` handshake at cycle N: RECV from N+1. A `urx_valid` at N+1 is captured.
- 64th `urx_valid` at cycle M: `out_valid`=1 at M+1.
- Final `out` handshake at cycle K: `in_ready`=1 at K+1, and `blk_count` updated at K+1.
- `utx_data` and `out_data` stay stable while valid is high and ready is low.
- `rst` in any state takes priority on the next edge; any in-flight block is abandoned.

## Test plan
- Send 64 bytes 0x00..0x3F (no `in_last`) with `utx_ready`=1, using a model engine that returns `byte^0xA5`. Required: `utx` carries 0x00..0x3F; `out` carries 0xA5..0x9A (64 bytes); `out_last`=0 throughout; `blk_count`=1.
- Send 0x11, 0x22, 0x33 with `in_last` on the third byte. Required: `utx` carries 11 22 33 then 61×0x00. The engine returns 64 bytes; `out` emits exactly B4 87 96 with `out_last` on the third byte; `blk_count`=1.
- Toggle `utx_ready` every cycle and hold `out_ready`=0 for 10 cycles mid-DRAIN. Required: no byte lost or duplicated; `out_data` is held stable.
- With `TIMEOUT_CYCLES`=100, the engine returns 10 bytes then stops. Required: `err`=1 exactly 100 cycles after the 10th `urx_valid`; all valids and readies are 0; `err` clears only on `rst`.
- Drive stray `urx_valid` bytes 0xEE during FILL and SEND. Required: they are ignored, and the response for the next block is correct.
- Assert `rst` for 1 cycle at byte 30 of RECV. Required: all reset values hold with `blk_count`=0; the next full block completes normally.

Source files
------------

// File: rtl/chacha_block_client.sv
// Initiator-side client for the UART ChaCha20 block engine: packs plaintext into
// 64-byte blocks, ships them over uart_tx, collects the keystream-XORed reply and replays it.
module chacha_block_client #(
   parameter int          BLOCK_BYTES    = 64,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd27_000_000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  in_data_i,
   input  logic        in_valid_i,
   input  logic        in_last_i,
   output logic        in_ready_o,
   output logic [7:0]  utx_data_o,
   output logic        utx_valid_o,
   input  logic        utx_ready_i,
   input  logic [7:0]  urx_data_i,
   input  logic        urx_valid_i,
   output logic [7:0]  out_data_o,
   output logic        out_valid_o,
   output logic        out_last_o,
   input  logic        out_ready_i,
   output logic [31:0] blk_count_o,
   output logic        busy_o,
   output logic        err_o
);

   typedef enum logic [2:0] {
      S_FILL,
      S_SEND,
      S_RECV,
      S_DRAIN,
      S_ERR
   } state_t;

   localparam logic [6:0] LAST_IDX = 7'(BLOCK_BYTES - 1);

   state_t      state_q, state_d;
   logic [6:0]  idx_q, idx_d;
   logic [6:0]  len_q, len_d;
   logic        last_q, last_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] blk_q, blk_d;
   logic        tx_we, rx_we;

   logic [7:0]  tx_buf [BLOCK_BYTES];
   logic [7:0]  rx_buf [BLOCK_BYTES];

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      last_d  = last_q;
      timer_d = timer_q;
      blk_d   = blk_q;
      tx_we   = 1'b0;
      rx_we   = 1'b0;
      case (state_q)
         S_FILL: begin
            if (in_valid_i) begin
               tx_we = 1'b1;
               if (in_last_i || idx_q == LAST_IDX) begin
                  len_d   = idx_q + 7'd1;
                  last_d  = in_last_i;
                  idx_d   = 7'd0;
                  state_d = S_SEND;
               end else begin
                  idx_d = idx_q + 7'd1;
               end
            end
         end
         S_SEND: begin
            if (utx_ready_i) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = 7'd0;
                  timer_d = 32'd0;
                  state_d = S_RECV;
               end else begin
                  idx_d = idx_q + 7'd1;
               end
            end
         end
         S_RECV: begin
            // A byte landing on the expiry cycle still counts; the watchdog loses.
            if (urx_valid_i) begin
               rx_we   = 1'b1;
               timer_d = 32'd0;
               if (idx_q == LAST_IDX) begin
                  idx_d   = 7'd0;
                  state_d = S_DRAIN;
               end else begin
                  idx_d = idx_q + 7'd1;
               end
            end else if (timer_q == TIMEOUT_CYCLES - 32'd1) begin
               state_d = S_ERR;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         S_DRAIN: begin
            if (out_ready_i) begin
               if (idx_q == len_q - 7'd1) begin
                  blk_d   = blk_q + 32'd1;
                  idx_d   = 7'd0;
                  state_d = S_FILL;
               end else begin
                  idx_d = idx_q + 7'd1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_FILL;
         idx_q   <= 7'd0;
         len_q   <= 7'd1;
         last_q  <= 1'b0;
         timer_q <= 32'd0;
         blk_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         last_q  <= last_d;
         timer_q <= timer_d;
         blk_q   <= blk_d;
      end
   end

   // Buffers are never cleared; contents are only meaningful below len_q.
   always_ff @(posedge clk_i) begin
      if (tx_we) begin
         tx_buf[idx_q[5:0]] <= in_data_i;
      end
      if (rx_we) begin
         rx_buf[idx_q[5:0]] <= urx_data_i;
      end
   end

   assign in_ready_o  = (state_q == S_FILL) && !rst_i;
   assign utx_valid_o = (state_q == S_SEND);
   assign utx_data_o  = (state_q == S_SEND && idx_q < len_q) ? tx_buf[idx_q[5:0]] : 8'h00;
   assign out_valid_o = (state_q == S_DRAIN);
   assign out_data_o  = (state_q == S_DRAIN) ? rx_buf[idx_q[5:0]] : 8'h00;
   assign out_last_o  = (state_q == S_DRAIN) && last_q && (idx_q == len_q - 7'd1);
   assign blk_count_o = blk_q;
   assign busy_o      = (state_q != S_FILL) || (idx_q != 7'd0);
   assign err_o       = (state_q == S_ERR);

endmodule

// File: tb/tb_chacha_block_client.sv
// Directed bench for chacha_block_client; a model engine answers each block with byte^0xA5.
module tb_chacha_block_client;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic [7:0]  utx_data;
   logic        utx_valid;
   logic        utx_ready = 1'b0;
   logic [7:0]  urx_data = 8'h00;
   logic        urx_valid = 1'b0;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_last;
   logic        out_ready = 1'b0;
   logic [31:0] blk_count;
   logic        busy;
   logic        err;

   chacha_block_client #(
      .BLOCK_BYTES   (64),
      .TIMEOUT_CYCLES(32'd100)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .in_data_i  (in_data),
      .in_valid_i (in_valid),
      .in_last_i  (in_last),
      .in_ready_o (in_ready),
      .utx_data_o (utx_data),
      .utx_valid_o(utx_valid),
      .utx_ready_i(utx_ready),
      .urx_data_i (urx_data),
      .urx_valid_i(urx_valid),
      .out_data_o (out_data),
      .out_valid_o(out_valid),
      .out_last_o (out_last),
      .out_ready_i(out_ready),
      .blk_count_o(blk_count),
      .busy_o     (busy),
      .err_o      (err)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [7:0]  pdata  [64];
   int          plen;
   bit          plast;
   logic [7:0]  txcap  [64];
   logic [7:0]  outcap [64];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; urx_valid = 1'b0;
      utx_ready = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("in_ready_during_rst", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_utx_valid", {31'd0, utx_valid}, 32'd0);
      chk("rst_utx_data",  {24'd0, utx_data},  32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data",  {24'd0, out_data},  32'd0);
      chk("rst_out_last",  {31'd0, out_last},  32'd0);
      chk("rst_blk_count", blk_count,          32'd0);
      chk("rst_busy",      {31'd0, busy},      32'd0);
      chk("rst_err",       {31'd0, err},       32'd0);
   endtask

   task automatic push(input bit stray);
      for (int i = 0; i < plen; i++) begin
         @(negedge clk);
         if (i == 0) chk("in_ready_fill", {31'd0, in_ready}, 32'd1);
         in_valid  = 1'b1;
         in_data   = pdata[i];
         in_last   = plast && (i == plen - 1);
         urx_valid = stray && (i % 2 == 0);
         urx_data  = 8'hEE;
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; urx_valid = 1'b0;
      chk("utx_valid_after_fill", {31'd0, utx_valid}, 32'd1);
      chk("in_ready_in_send",     {31'd0, in_ready},  32'd0);
      chk("busy_in_send",         {31'd0, busy},      32'd1);
   endtask

   task automatic tx_phase(input bit toggle, input bit stray);
      int         n = 0;
      bit         held = 1'b0;
      logic [7:0] prev = 8'h00;
      for (int c = 0; c < 400 && n < 64; c++) begin
         @(negedge clk);
         if (held) chk("utx_data_hold", {24'd0, utx_data}, {24'd0, prev});
         utx_ready = toggle ? c[0] : 1'b1;
         urx_valid = stray && (c % 3 == 0);
         urx_data  = 8'hEE;
         held = 1'b0;
         if (utx_valid) begin
            if (utx_ready) begin
               txcap[n] = utx_data;
               chk("utx_data", {24'd0, utx_data}, (n < plen) ? {24'd0, pdata[n]} : 32'd0);
               n++;
            end else begin
               held = 1'b1;
               prev = utx_data;
            end
         end
      end
      chk("utx_count", n, 64);
   endtask

   task automatic rx_phase(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         utx_ready = 1'b0;
         urx_valid = 1'b1;
         urx_data  = txcap[i] ^ 8'hA5;
      end
      @(negedge clk);
      utx_ready = 1'b0;
      urx_valid = 1'b0;
   endtask

   task automatic drain(input bit stall, input int exp_blk);
      int         n = 0;
      int         st = 0;
      bit         held = 1'b0;
      logic [7:0] prev = 8'h00;
      chk("out_valid_after_recv", {31'd0, out_valid}, 32'd1);
      for (int c = 0; c < 400 && n < plen; c++) begin
         @(negedge clk);
         if (held) chk("out_data_hold", {24'd0, out_data}, {24'd0, prev});
         if (stall && n == 5 && st < 10) begin
            out_ready = 1'b0;
            st++;
         end else begin
            out_ready = 1'b1;
         end
         held = 1'b0;
         if (out_valid) begin
            if (out_ready) begin
               outcap[n] = out_data;
               chk("out_data", {24'd0, out_data}, {24'd0, pdata[n] ^ 8'hA5});
               chk("out_last", {31'd0, out_last}, {31'd0, plast && (n == plen - 1)});
               n++;
            end else begin
               held = 1'b1;
               prev = out_data;
            end
         end
      end
      chk("out_count", n, plen);
      @(negedge clk);
      out_ready = 1'b0;
      chk("out_valid_after_drain", {31'd0, out_valid}, 32'd0);
      chk("in_ready_after_drain",  {31'd0, in_ready},  32'd1);
      chk("blk_count",             blk_count,          exp_blk);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "bench time limit expired");
   end

   initial begin
      do_reset();

      // Full 64-byte block, no in_last, ready always high.
      for (int i = 0; i < 64; i++) pdata[i] = 8'(i);
      plen = 64; plast = 1'b0;
      push(1'b0);
      tx_phase(1'b0, 1'b0);
      rx_phase(64);
      drain(1'b0, 1);
      chk("t1_first_out", {24'd0, outcap[0]},  32'h0000_00A5);
      chk("t1_last_out",  {24'd0, outcap[63]}, 32'h0000_009A);

      // Exact multiple of 64 with in_last, utx_ready toggling, mid-drain stall.
      for (int i = 0; i < 64; i++) pdata[i] = 8'(i * 7 + 3);
      plen = 64; plast = 1'b1;
      push(1'b0);
      tx_phase(1'b1, 1'b0);
      rx_phase(64);
      drain(1'b1, 2);

      // Reset during RECV after 30 returned bytes, then a clean block.
      for (int i = 0; i < 64; i++) pdata[i] = 8'(255 - i);
      plen = 64; plast = 1'b0;
      push(1'b0);
      tx_phase(1'b0, 1'b0);
      rx_phase(30);
      chk("busy_in_recv", {31'd0, busy}, 32'd1);
      do_reset();
      push(1'b0);
      tx_phase(1'b0, 1'b0);
      rx_phase(64);
      drain(1'b0, 1);

      // Short final block with stray uart_rx bytes during FILL and SEND.
      do_reset();
      pdata[0] = 8'h11; pdata[1] = 8'h22; pdata[2] = 8'h33;
      plen = 3; plast = 1'b1;
      push(1'b1);
      tx_phase(1'b0, 1'b1);
      rx_phase(64);
      drain(1'b0, 1);
      chk("t2_out0", {24'd0, outcap[0]}, 32'h0000_00B4);
      chk("t2_out1", {24'd0, outcap[1]}, 32'h0000_0087);
      chk("t2_out2", {24'd0, outcap[2]}, 32'h0000_0096);

      // Engine stalls after 10 bytes; watchdog must fire 100 cycles later.
      for (int i = 0; i < 5; i++) pdata[i] = 8'(i + 8'h40);
      plen = 5; plast = 1'b1;
      push(1'b0);
      tx_phase(1'b0, 1'b0);
      rx_phase(10);
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (k == 99)  chk("err_before_timeout", {31'd0, err}, 32'd0);
         if (k == 100) begin
            chk("err_at_timeout",   {31'd0, err},       32'd1);
            chk("err_in_ready",     {31'd0, in_ready},  32'd0);
            chk("err_utx_valid",    {31'd0, utx_valid}, 32'd0);
            chk("err_out_valid",    {31'd0, out_valid}, 32'd0);
         end
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = 1'b1; urx_valid = 1'b1; urx_data = 8'h55;
         utx_ready = 1'b1; out_ready = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0; urx_valid = 1'b0; utx_ready = 1'b0; out_ready = 1'b0;
      chk("err_sticky",          {31'd0, err},      32'd1);
      chk("err_sticky_in_ready", {31'd0, in_ready}, 32'd0);
      do_reset();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
